ring_buffer_ctrl: RTL and testbench
===================================

RING_BUFFER_CTRL -- requirements
Module: ring_buffer_ctrl

Interface
REQ-001 Parameter WIDTH, default 4, SHALL set the pointer width in bits.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst  input  1  SHALL be the reset: synchronous, active-high.
REQ-004 max  input  WIDTH  SHALL give the highest valid slot index (depth = max+1), captured only while rst=1.
REQ-005 wr_en  input  1  SHALL be the producer write request.
REQ-006 rd_en  input  1  SHALL be the consumer read request.
REQ-007 wr_fire  output  1  SHALL be high when the write is accepted this cycle (combinational).
REQ-008 rd_fire  output  1  SHALL be high when the read is accepted this cycle (combinational).
REQ-009 wr_addr  output  WIDTH  SHALL be the slot the next accepted write uses (registered).
REQ-010 rd_addr  output  WIDTH  SHALL be the slot the next accepted read uses (registered).
REQ-011 count  output  WIDTH+1  SHALL be the occupied slot count (registered).
REQ-012 full, empty  output  1 each  SHALL flag count==max_q+1 and count==0 respectively (combinational from registers).

Function
REQ-013 rd_fire SHALL equal rd_en & ~empty.
REQ-014 wr_fire SHALL equal wr_en & (~full | rd_fire): when full, a simultaneous read frees the slot and the write is accepted in the same cycle.
REQ-015 Pointer advance SHALL use circular increment: next = (ptr+1 > max_q) ? 0 : ptr+1, computed at WIDTH+1 bits so max_q = 2^WIDTH-1 wraps correctly.
REQ-016 On wr_fire, wr_addr SHALL advance; on rd_fire, rd_addr SHALL advance; both may advance in the same cycle.
REQ-017 count SHALL +1 on wr_fire only, -1 on rd_fire only, and hold when both or neither fire.
REQ-018 When empty, simultaneous wr_en and rd_en SHALL accept only the write (no fall-through); count becomes 1.
REQ-019 max_q SHALL hold its value whenever rst=0; max changes outside reset SHALL have no effect.
REQ-020 max_q = 0 SHALL give depth 1: full after one write, and both pointers stay at 0.
REQ-021 Latency: address and flag changes SHALL be visible the cycle after the accepting edge.

Reset
REQ-022 While rst=1 at a rising edge: wr_addr=0, rd_addr=0, count=0, max_q=max; hence empty=1, full=0 (with max_q>=0) and wr_fire/rd_fire follow REQ-013/014 from the reset state.
REQ-023 Reset asserted mid-operation SHALL discard all occupancy in one cycle regardless of wr_en/rd_en.

Configuration
REQ-024 Macro RING_BUFFER_CTRL_ERR_EN defined: add outputs overflow and underflow (1 bit each), sticky, cleared only by rst; overflow sets on wr_en & ~wr_fire, underflow sets on rd_en & ~rd_fire.
REQ-025 Macro undefined: those ports and their logic SHALL not exist; all other behaviour identical.

Structure
REQ-026 The circular-increment rule SHALL be implemented by instantiating the existing circular_adder sub-module (a=ptr, b=1, max=max_q), once per pointer.
REQ-027 No shared package SHALL be needed; WIDTH is the only constant, and count width is derived as WIDTH+1 locally.

Verification (WIDTH=4)
REQ-028 rst with max=5, then 6 writes -> wr_addr 1,2,3,4,5,0; count=6; full=1; 7th wr_en gives wr_fire=0.
REQ-029 Full at max=5, wr_en=rd_en=1 for 1 cycle -> both fire; count stays 6; rd_addr 0->1, wr_addr 0->1.
REQ-030 Empty, wr_en=rd_en=1 -> wr_fire=1, rd_fire=0; next cycle count=1, empty=0.
REQ-031 max=15: 16 writes then 16 reads -> pointers wrap 15->0; empty=1 at end; max changed to 3 mid-run has no effect.
REQ-032 max=0: one write -> full=1; read -> empty=1; both pointers remain 0 throughout.
REQ-033 With RING_BUFFER_CTRL_ERR_EN: rd_en on empty -> underflow=1 and stays set until rst; write on full without read -> overflow=1.

Source files
------------

// File: rtl/ring_buffer_ctrl_circular_adder.sv
// circular_adder: modular add that wraps to zero past max, evaluated one bit wider than the operands
module circular_adder #(
   parameter int WIDTH = 4
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [WIDTH-1:0] max,
   output logic [WIDTH-1:0] sum
);
   logic [WIDTH:0] raw;
   // wide sum so a+b above 2^WIDTH-1 is still seen as exceeding max
   always_comb begin
      raw = {1'b0, a} + {1'b0, b};
      sum = (raw > {1'b0, max}) ? '0 : raw[WIDTH-1:0];
   end
endmodule

// File: rtl/ring_buffer_ctrl.sv
// ring_buffer_ctrl: pointer/occupancy controller for a ring buffer of depth max+1; RING_BUFFER_CTRL_ERR_EN adds sticky overflow/underflow
module ring_buffer_ctrl #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] max,
   input  logic             wr_en,
   input  logic             rd_en,
   output logic             wr_fire,
   output logic             rd_fire,
   output logic [WIDTH-1:0] wr_addr,
   output logic [WIDTH-1:0] rd_addr,
   output logic [WIDTH:0]   count,
   output logic             full,
   output logic             empty
`ifdef RING_BUFFER_CTRL_ERR_EN
   ,
   output logic             overflow,
   output logic             underflow
`endif
);
   localparam logic [WIDTH-1:0] inc = 1;
   localparam logic [WIDTH:0] one = 1;
   logic [WIDTH-1:0] max_q;
   logic [WIDTH-1:0] wr_next;
   logic [WIDTH-1:0] rd_next;
   circular_adder #(.WIDTH(WIDTH)) u_wr_inc (.a(wr_addr), .b(inc), .max(max_q), .sum(wr_next));
   circular_adder #(.WIDTH(WIDTH)) u_rd_inc (.a(rd_addr), .b(inc), .max(max_q), .sum(rd_next));
   // flags from registered state; a read on full frees the slot for a same-cycle write
   always_comb begin
      full    = count == ({1'b0, max_q} + one);
      empty   = count == '0;
      rd_fire = rd_en & ~empty;
      wr_fire = wr_en & (~full | rd_fire);
   end
   // depth is latched only in reset; pointers and occupancy follow the accepted transfers
   always_ff @(posedge clk) begin
      if (rst) begin
         max_q   <= max;
         wr_addr <= '0;
         rd_addr <= '0;
         count   <= '0;
      end else begin
         if (wr_fire) wr_addr <= wr_next;
         if (rd_fire) rd_addr <= rd_next;
         count <= (wr_fire & ~rd_fire) ? count + one :
                  (rd_fire & ~wr_fire) ? count - one : count;
      end
   end
`ifdef RING_BUFFER_CTRL_ERR_EN
   // sticky record of any rejected request
   always_ff @(posedge clk) begin
      if (rst) begin
         overflow  <= 1'b0;
         underflow <= 1'b0;
      end else begin
         if (wr_en & ~wr_fire) overflow <= 1'b1;
         if (rd_en & ~rd_fire) underflow <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_ring_buffer_ctrl.sv
// tb_ring_buffer_ctrl: directed and random checks of ring_buffer_ctrl against a transfer-counting model
module tb_ring_buffer_ctrl;
   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [3:0] max = '0;
   logic       wr_en = 1'b0;
   logic       rd_en = 1'b0;
   logic       wr_fire, rd_fire, full, empty;
   logic [3:0] wr_addr, rd_addr;
   logic [4:0] count;
`ifdef RING_BUFFER_CTRL_ERR_EN
   logic       overflow, underflow;
   int         m_ovf, m_unf;
`endif
   int tests = 0;
   int fails = 0;
   int depth, wc, rc;

   ring_buffer_ctrl #(.WIDTH(4)) dut (
      .clk(clk), .rst(rst), .max(max), .wr_en(wr_en), .rd_en(rd_en),
      .wr_fire(wr_fire), .rd_fire(rd_fire), .wr_addr(wr_addr), .rd_addr(rd_addr),
      .count(count), .full(full), .empty(empty)
`ifdef RING_BUFFER_CTRL_ERR_EN
      , .overflow(overflow), .underflow(underflow)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input int obs, input int exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic chk_state();
      chk("wr_addr", int'(wr_addr), wc % depth);
      chk("rd_addr", int'(rd_addr), rc % depth);
      chk("count", int'(count), wc - rc);
      chk("full", int'(full), int'(wc - rc == depth));
      chk("empty", int'(empty), int'(wc == rc));
`ifdef RING_BUFFER_CTRL_ERR_EN
      chk("overflow", int'(overflow), m_ovf);
      chk("underflow", int'(underflow), m_unf);
`endif
   endtask

   task automatic do_reset(input int m);
      rst = 1'b1;
      max = 4'(m);
      wr_en = 1'b0;
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      depth = m + 1;
      wc = 0;
      rc = 0;
`ifdef RING_BUFFER_CTRL_ERR_EN
      m_ovf = 0;
      m_unf = 0;
`endif
      chk_state();
   endtask

   task automatic step(input logic w, input logic r);
      int occ;
      int er, ew;
      wr_en = w;
      rd_en = r;
      #1;
      occ = wc - rc;
      er = int'(r && occ > 0);
      ew = int'(w && (occ < depth || er == 1));
      chk("rd_fire", int'(rd_fire), er);
      chk("wr_fire", int'(wr_fire), ew);
      @(posedge clk);
      #1;
      wc += ew;
      rc += er;
`ifdef RING_BUFFER_CTRL_ERR_EN
      if (w && ew == 0) m_ovf = 1;
      if (r && er == 0) m_unf = 1;
`endif
      chk_state();
   endtask

   initial begin
      @(posedge clk);
      #1;
      do_reset(5);
      for (int i = 0; i < 6; i++) step(1'b1, 1'b0);
      chk("full_after_6", int'(full), 1);
      step(1'b1, 1'b0);
      step(1'b1, 1'b1);
      chk("both_count", int'(count), 6);
      do_reset(5);
      step(1'b1, 1'b1);
      chk("fallthru_count", int'(count), 1);
      do_reset(15);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) max = 4'd3;
         step(1'b1, 1'b0);
      end
      chk("full16", int'(full), 1);
      for (int i = 0; i < 16; i++) step(1'b0, 1'b1);
      chk("empty16", int'(empty), 1);
      do_reset(0);
      step(1'b1, 1'b0);
      step(1'b1, 1'b0);
      step(1'b0, 1'b1);
      step(1'b0, 1'b1);
      chk("max0_rd_addr", int'(rd_addr), 0);
      for (int k = 0; k < 4; k++) begin
         do_reset(int'($urandom_range(0, 15)));
         for (int i = 0; i < 120; i++) step(1'($urandom), 1'($urandom));
         max = 4'($urandom);
      end
      do_reset(2);
      step(1'b1, 1'b0);
      rst = 1'b1;
      wr_en = 1'b1;
      rd_en = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      wr_en = 1'b0;
      wc = 0;
      rc = 0;
      chk_state();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
